// File: rtl/type_decode_stage.sv
// -----------------------------------------------------------------------------
// type_decode_stage
// Registered, handshaked RV32I instruction-type decode stage with load-use
// interlock. The major opcode is classified into a one-hot type vector and
// the instruction is passed through with one cycle of latency. After a load
// leaves the stage, intake stalls until the data memory answers (mem_valid)
// or LOAD_TIMEOUT cycles elapse, whichever comes first.
//
// Build option: define TYPE_DECODE_ILLEGAL_EN to flag unmapped opcodes on
// type_vec[9]; otherwise type_vec[9] is tied low and unmapped opcodes pass
// through with type_vec=0.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   instr_in     instruction from fetch        in_valid / in_ready handshake
//   instr_out    registered instruction        out_valid / out_ready handshake
//   type_vec     one-hot type: [0]r [1]i [2]load [3]store [4]branch [5]jal
//                [6]jalr [7]lui [8]auipc [9]illegal (zero while !out_valid)
//   mem_valid    data-memory load response valid
//   load_busy    stage is waiting for a load response
//   load_timeout one-cycle pulse when the load wait is aborted
// -----------------------------------------------------------------------------
module type_decode_stage #(
  parameter int ILEN         = 32,
  parameter int LOAD_TIMEOUT = 15,
  parameter int CNT_W        = $clog2(LOAD_TIMEOUT + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [ILEN-1:0] instr_in,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [ILEN-1:0] instr_out,
  output logic [9:0]      type_vec,
  output logic            out_valid,
  input  logic            out_ready,
  input  logic            mem_valid,
  output logic            load_busy,
  output logic            load_timeout
);

  localparam logic S_IDLE      = 1'b0;
  localparam logic S_LOAD_WAIT = 1'b1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOAD_TIMEOUT - 1);

  logic            r_state;
  logic [CNT_W-1:0] r_cnt;
  logic            r_out_valid;
  logic [ILEN-1:0] r_instr;
  logic [9:0]      r_type;
  logic            r_timeout;

  logic            w_accept;
  logic            w_out_xfer;
  logic [9:0]      w_dec;

  assign in_ready   = (r_state == S_IDLE) & (~r_out_valid | out_ready);
  assign w_accept   = in_valid & in_ready;
  assign w_out_xfer = r_out_valid & out_ready;

  assign instr_out    = r_instr;
  assign type_vec     = r_type;
  assign out_valid    = r_out_valid;
  assign load_busy    = (r_state == S_LOAD_WAIT);
  assign load_timeout = r_timeout;

  // Every mapped opcode has [1:0]==2'b11, so the default arm also covers
  // the compressed/non-32-bit encodings.
  always_comb begin
    w_dec = '0;
    case (instr_in[6:0])
      7'b0110011: w_dec[0] = 1'b1;
      7'b0010011: w_dec[1] = 1'b1;
      7'b0000011: w_dec[2] = 1'b1;
      7'b0100011: w_dec[3] = 1'b1;
      7'b1100011: w_dec[4] = 1'b1;
      7'b1101111: w_dec[5] = 1'b1;
      7'b1100111: w_dec[6] = 1'b1;
      7'b0110111: w_dec[7] = 1'b1;
      7'b0010111: w_dec[8] = 1'b1;
`ifdef TYPE_DECODE_ILLEGAL_EN
      default:    w_dec[9] = 1'b1;
`else
      default:    w_dec    = '0;
`endif
    endcase
  end

  // Output register: a same-cycle accept replaces the presented instruction,
  // so streaming runs without bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_instr     <= '0;
      r_type      <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_instr     <= instr_in;
      r_type      <= w_dec;
    end else if (w_out_xfer) begin
      r_out_valid <= 1'b0;
      r_type      <= '0;
    end
  end

  // Load-use interlock. The counter counts cycles spent waiting; it leaves
  // at CNT_LAST, so it never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_out_xfer && r_type[2] && !mem_valid)
            r_state <= S_LOAD_WAIT;
        end
        S_LOAD_WAIT: begin
          if (mem_valid) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_timeout <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_type_decode_stage.sv
module tb_type_decode_stage;

  localparam int ILEN = 32;
  localparam int LT   = 15;

`ifdef TYPE_DECODE_ILLEGAL_EN
  localparam logic [9:0] T_ILL = 10'h200;
`else
  localparam logic [9:0] T_ILL = 10'h000;
`endif

  localparam logic [31:0] I_ADD  = 32'h00B50533;
  localparam logic [31:0] I_ADDI = 32'h00150513;
  localparam logic [31:0] I_SW   = 32'h00A52023;
  localparam logic [31:0] I_JAL  = 32'h0000006F;
  localparam logic [31:0] I_LW   = 32'h00052503;

  logic            clk;
  logic            rst;
  logic [ILEN-1:0] instr_in;
  logic            in_valid;
  logic            in_ready;
  logic [ILEN-1:0] instr_out;
  logic [9:0]      type_vec;
  logic            out_valid;
  logic            out_ready;
  logic            mem_valid;
  logic            load_busy;
  logic            load_timeout;

  type_decode_stage #(.ILEN(ILEN), .LOAD_TIMEOUT(LT)) dut (
    .clk(clk), .rst(rst),
    .instr_in(instr_in), .in_valid(in_valid), .in_ready(in_ready),
    .instr_out(instr_out), .type_vec(type_vec),
    .out_valid(out_valid), .out_ready(out_ready),
    .mem_valid(mem_valid), .load_busy(load_busy), .load_timeout(load_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [9:0]  typ;
  } vec_t;

  vec_t vecs[10];
  vec_t sb[$];

  int checks = 0;
  int errors = 0;

  logic s_rdy, s_ov, s_busy, s_to;
  logic [9:0] s_type;
  logic [31:0] s_instr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock cycle: drive at the falling edge, sample 1 ns later, score any
  // transfer that will happen at the next rising edge.
  task automatic cycle(input logic v, input logic [31:0] ins,
                       input logic ordy, input logic mv);
    vec_t e;
    @(negedge clk);
    in_valid  = v;
    instr_in  = ins;
    out_ready = ordy;
    mem_valid = mv;
    #1;
    s_rdy = in_ready; s_ov = out_valid; s_busy = load_busy;
    s_to = load_timeout; s_type = type_vec; s_instr = instr_out;
    if (s_ov && ordy) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", 32'(s_type), 32'h3FF);
      end else begin
        e = sb.pop_front();
        chk("out_instr", s_instr, e.instr);
        chk("out_type", 32'(s_type), 32'(e.typ));
      end
    end
    if (v && s_rdy) begin
      e.instr = ins;
      e.typ   = (ins == I_LW) ? 10'h004 : 10'h000;
      for (int k = 0; k < 10; k++)
        if (vecs[k].instr == ins) e.typ = vecs[k].typ;
      if (ins == I_JAL) e.typ = 10'h020;
      if (ins == I_ADD) e.typ = 10'h001;
      sb.push_back(e);
    end
    @(posedge clk);
  endtask

  initial begin
    int n;
    vecs[0] = '{I_ADD,        10'h001};
    vecs[1] = '{I_ADDI,       10'h002};
    vecs[2] = '{I_SW,         10'h008};
    vecs[3] = '{32'h00B50463, 10'h010};
    vecs[4] = '{I_JAL,        10'h020};
    vecs[5] = '{32'h00008067, 10'h040};
    vecs[6] = '{32'h000012B7, 10'h080};
    vecs[7] = '{32'h00001297, 10'h100};
    vecs[8] = '{32'h0000007F, T_ILL};
    vecs[9] = '{32'h00000031, T_ILL};

    rst = 1'b1; in_valid = 1'b0; instr_in = '0; out_ready = 1'b0; mem_valid = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_type_vec", 32'(type_vec), 0);
    chk("rst_instr_out", instr_out, 0);
    chk("rst_load_busy", 32'(load_busy), 0);
    chk("rst_load_timeout", 32'(load_timeout), 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;

    // Back-to-back streaming through the whole decode table.
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, vecs[i].instr, 1'b1, 1'b0);
      chk("stream_in_ready", 32'(s_rdy), 1);
    end
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    chk("stream_drained", 32'(sb.size()), 0);

    // Backpressure: jal held for 3 cycles, then released with a same-cycle accept.
    cycle(1'b1, I_JAL, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, I_ADD, 1'b0, 1'b0);
      chk("bp_in_ready", 32'(s_rdy), 0);
      chk("bp_out_valid", 32'(s_ov), 1);
      chk("bp_type_vec", 32'(s_type), 32'h020);
      chk("bp_instr_out", s_instr, I_JAL);
    end
    cycle(1'b1, I_ADD, 1'b1, 1'b0);
    chk("bp_release_ready", 32'(s_rdy), 1);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    chk("bp_no_bubble", 32'(s_ov), 1);
    chk("bp_drained", 32'(sb.size()), 0);

    // Load wait answered by mem_valid on the 4th waiting cycle.
    cycle(1'b1, I_LW, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, I_ADD, 1'b1, (i == 3));
      chk("lw_busy", 32'(s_busy), 1);
      chk("lw_in_ready", 32'(s_rdy), 0);
      chk("lw_no_timeout", 32'(s_to), 0);
    end
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    chk("lw_done_busy", 32'(s_busy), 0);
    chk("lw_done_ready", 32'(s_rdy), 1);
    chk("lw_done_timeout", 32'(s_to), 0);

    // Load timeout: mem_valid never arrives.
    cycle(1'b1, I_LW, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    n = 0;
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    while (s_busy && n < 40) begin
      n++;
      chk("to_pulse_early", 32'(s_to), 0);
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
    end
    chk("to_busy_cycles", n, LT);
    chk("to_pulse", 32'(s_to), 1);
    chk("to_in_ready", 32'(s_rdy), 1);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    chk("to_pulse_single", 32'(s_to), 0);

    // Load with mem_valid coincident on its output transfer: no wait.
    cycle(1'b1, I_LW, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b1);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    chk("lwc_busy", 32'(s_busy), 0);
    chk("lwc_in_ready", 32'(s_rdy), 1);
    chk("lwc_drained", 32'(sb.size()), 0);

    // Asynchronous reset while waiting on a load with an output held.
    cycle(1'b1, I_LW, 1'b1, 1'b0);
    cycle(1'b1, I_ADD, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    chk("mid_busy", 32'(s_busy), 1);
    chk("mid_out_valid", 32'(s_ov), 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_type_vec", 32'(type_vec), 0);
    chk("arst_load_busy", 32'(load_busy), 0);
    sb.delete();
    @(negedge clk); rst = 1'b0;
    #1;
    chk("arst_in_ready", 32'(in_ready), 1);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    chk("final_out_valid", 32'(s_ov), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/type_decode_stage.md
Name: type_decode_stage

Overview:
Registered, handshaked instruction-type decode stage placed between fetch and the execute/control path. It classifies the RV32I major opcode into a one-hot type vector and passes the instruction through. It also owns the load-use interlock: after a load is handed downstream, it stalls intake until the data memory returns valid or a programmable timeout expires.

Parameters:
ILEN, 32, instruction width in bits; must be at least 7.
LOAD_TIMEOUT, 15, maximum cycles spent in LOAD_WAIT before abort; must be at least 1.
CNT_W, $clog2(LOAD_TIMEOUT+1), width of the wait counter.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
instr_in  in  ILEN  instruction from fetch
in_valid  in  1  instr_in valid
in_ready  out  1  stage can accept instr_in
instr_out  out  ILEN  registered copy of the accepted instruction
type_vec  out  10  one-hot type: [0]r_type [1]i_type [2]load [3]store [4]branch [5]jal [6]jalr [7]lui [8]auipc [9]illegal
out_valid  out  1  instr_out/type_vec valid
out_ready  in  1  downstream accepts
mem_valid  in  1  data-memory load response valid
load_busy  out  1  FSM is in LOAD_WAIT
load_timeout  out  1  one-cycle pulse on LOAD_WAIT abort

Behaviour:
- Reset (asynchronous, immediate): out_valid=0, instr_out=0, type_vec=0, state=IDLE, counter=0, load_busy=0, load_timeout=0.
- Opcode map, using instr_in[6:0]:
  - 0110011 -> r_type; 0010011 -> i_type; 0000011 -> load; 0100011 -> store; 1100011 -> branch.
  - 1101111 -> jal; 1100111 -> jalr; 0110111 -> lui; 0010111 -> auipc.
  - Any other value -> illegal (see optional feature).
- type_vec has at most one bit set. It is all-zero while out_valid=0.
- Input transfer: in_valid & in_ready. Output transfer: out_valid & out_ready.
- in_ready = (state==IDLE) & (!out_valid | out_ready). This is combinational, with no path from in_valid.
- Latency: 1 cycle. An instruction accepted at edge N is presented with out_valid=1 after edge N.
- out_valid, instr_out and type_vec hold stable until the output transfer. A new accept in the same cycle as an output transfer replaces the output with no bubble.
- FSM states:
  - IDLE -> LOAD_WAIT when an output transfer carries type_vec[2]=1 and mem_valid=0 in that same cycle.
  - If mem_valid=1 coincides with the load's output transfer, the FSM stays in IDLE.
  - LOAD_WAIT: in_ready=0, load_busy=1, counter increments each cycle.
  - LOAD_WAIT -> IDLE on mem_valid=1. Counter clears; no timeout pulse.
  - LOAD_WAIT -> IDLE when counter==LOAD_TIMEOUT-1 and mem_valid=0. load_timeout=1 for exactly the next cycle; counter clears.
  - If mem_valid and the timeout condition occur in the same cycle, mem_valid wins and no pulse is generated.
- mem_valid is ignored in IDLE.
- Reset asserted mid-LOAD_WAIT or mid-hold: return to IDLE immediately and drop any pending output.
- Counter never wraps; it saturates at LOAD_TIMEOUT-1 by construction.

Optional Feature:
TYPE_DECODE_ILLEGAL_EN
- Defined:
  - Unmapped opcodes, or instr_in[1:0]!=2'b11, set type_vec[9]=1 with all other bits 0.
  - An illegal instruction holds in the output register like any other and never enters LOAD_WAIT.
- Undefined:
  - type_vec[9] is tied to 0.
  - Unmapped opcodes produce type_vec=0 with out_valid=1 and pass through normally.

Test Plan:
1. Reset mid-stream: assert rst with out_valid=1 in LOAD_WAIT -> out_valid=0, type_vec=0, load_busy=0 with no clock edge required; in_ready=1 after release.
2. Back-to-back streaming: 0x00B50533 (add), 0x00150513 (addi), 0x00A52023 (sw) with out_ready=1 -> type_vec 0x001, 0x002, 0x008 on consecutive cycles; in_ready stays 1.
3. Backpressure: out_ready=0 for 3 cycles with 0x0000006F (jal) held -> type_vec=0x020 and instr_out stable; in_ready=0; release accepts the next instruction with no bubble.
4. Load wait: 0x00052503 (lw) transferred with mem_valid=0; mem_valid pulses 4 cycles later -> load_busy=1 for 4 cycles, in_ready=0, then IDLE; load_timeout stays 0.
5. Load timeout: LOAD_TIMEOUT=15, lw transferred, mem_valid never asserted -> load_busy high 15 cycles, then a single-cycle load_timeout; in_ready returns to 1.
6. Illegal/edge: 0x0000007F with TYPE_DECODE_ILLEGAL_EN -> type_vec=0x200 (without the macro -> 0x000); lw with mem_valid coincident on transfer -> no LOAD_WAIT entry.
